// File: rtl/miner_link_pkg.sv
// Shared state encodings and default framing bytes for the miner link controller.
// The optional statistics counters are enabled with the LINK_STATS_EN macro (see miner_link_ctrl).
package miner_link_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hAA;
  localparam logic [7:0] ACK_BYTE_DEF   = 8'hA5;
  localparam logic [7:0] NAK_BYTE_DEF   = 8'h5A;
  localparam logic [7:0] NONCE_MARK_DEF = 8'hC3;

  typedef enum logic [1:0] {
    R_SYNC = 2'd0,
    R_DATA = 2'd1,
    R_CSUM = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_LOAD = 2'd1,
    T_ARM  = 2'd2,
    T_WAIT = 2'd3
  } tx_state_t;

endpackage

// File: rtl/link_tx_sequencer.sv
// Serialises ACK/NAK responses and 5-byte nonce reports onto the byte-wide UART transmitter.
// Holds a single-entry response slot and the latched nonce of the report in flight.
module link_tx_sequencer
  import miner_link_pkg::*;
#(
  parameter logic [7:0] ACK_BYTE   = ACK_BYTE_DEF,
  parameter logic [7:0] NAK_BYTE   = NAK_BYTE_DEF,
  parameter logic [7:0] NONCE_MARK = NONCE_MARK_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ack_req,
  input  logic        nak_req,
  input  logic        tx_busy,
  input  logic [31:0] nonce_in,
  input  logic        nonce_valid,
  output logic        nonce_ready,
  output logic [7:0]  tx_data,
  output logic        tx_wr_en,
  output tx_state_t   tx_state
);

  tx_state_t   state, state_nx;
  logic        resp_pending;
  logic [7:0]  resp_byte;
  logic [39:0] out_sr;
  logic [2:0]  bytes_left;
  logic        ready_en;
  logic        start_resp, start_nonce, advance;

  // Nonce handshake: transfer when nonce_valid && nonce_ready at a rising edge;
  // ready is only offered from T_IDLE with no response waiting, so responses win.
  assign nonce_ready = ready_en && (state == T_IDLE) && !resp_pending;
  assign start_resp  = (state == T_IDLE) && resp_pending;
  assign start_nonce = nonce_ready && nonce_valid;
  assign advance     = (state == T_WAIT) && !tx_busy;
  assign tx_state    = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= T_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_wr_en = 1'b0;
    tx_data  = 8'h00;
    case (state)
      T_IDLE: if (start_resp || start_nonce) state_nx = T_LOAD;
      T_LOAD: begin
        tx_wr_en = 1'b1;
        tx_data  = out_sr[39:32];
        state_nx = T_ARM;
      end
      // The UART raises tx_busy a cycle late, so it is ignored here.
      T_ARM:  state_nx = T_WAIT;
      T_WAIT: if (!tx_busy) state_nx = (bytes_left == 3'd1) ? T_IDLE : T_LOAD;
      default: state_nx = T_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_pending <= 1'b0;
      resp_byte    <= 8'h00;
      out_sr       <= 40'h0;
      bytes_left   <= 3'd0;
      ready_en     <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      // A newer response replaces one that has not started yet.
      if (ack_req) begin
        resp_pending <= 1'b1;
        resp_byte    <= ACK_BYTE;
      end else if (nak_req) begin
        resp_pending <= 1'b1;
        resp_byte    <= NAK_BYTE;
      end else if (start_resp) begin
        resp_pending <= 1'b0;
      end

      if (start_resp) begin
        out_sr     <= {resp_byte, 32'h0};
        bytes_left <= 3'd1;
      end else if (start_nonce) begin
        out_sr     <= {NONCE_MARK, nonce_in};
        bytes_left <= 3'd5;
      end else if (advance) begin
        out_sr     <= {out_sr[31:0], 8'h00};
        bytes_left <= bytes_left - 3'd1;
      end
    end
  end

endmodule

// File: rtl/miner_link_ctrl.sv
// Link-layer controller: frames UART bytes into a checksummed block header and reports nonces.
// Define LINK_STATS_EN to add saturating bad-checksum and timeout counters.
module miner_link_ctrl
  import miner_link_pkg::*;
#(
  parameter int         HEADER_BYTES   = 80,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter logic [7:0] ACK_BYTE       = ACK_BYTE_DEF,
  parameter logic [7:0] NAK_BYTE       = NAK_BYTE_DEF,
  parameter logic [7:0] NONCE_MARK     = NONCE_MARK_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      rx_clear,
  output logic [7:0]                tx_data,
  output logic                      tx_wr_en,
  input  logic                      tx_busy,
  output logic [8*HEADER_BYTES-1:0] header_data,
  output logic                      header_valid,
  input  logic [31:0]               nonce_in,
  input  logic                      nonce_valid,
  output logic                      nonce_ready,
  output rx_state_t                 rx_state_dbg,
`ifdef LINK_STATS_EN
  output logic [15:0]               stat_bad_csum,
  output logic [15:0]               stat_timeouts,
`endif
  output tx_state_t                 tx_state_dbg
);

  localparam int HW = 8 * HEADER_BYTES;
  localparam int CW = $clog2(HEADER_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  rx_state_t     rx_state, rx_nx;
  logic [HW-1:0] staging;
  logic [CW-1:0] byte_cnt;
  logic [7:0]    csum;
  logic [TW-1:0] timer;
  logic          byte_take, csum_hit, csum_miss, timeout_hit;

  // rx_valid is a level held until cleared; the cycle of the clear pulse must not re-take it.
  assign byte_take    = rx_valid && !rx_clear;
  assign rx_state_dbg = rx_state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rx_state <= R_SYNC;
    else       rx_state <= rx_nx;
  end

  always_comb begin
    rx_nx       = rx_state;
    csum_hit    = 1'b0;
    csum_miss   = 1'b0;
    timeout_hit = 1'b0;
    case (rx_state)
      R_SYNC: if (byte_take && rx_data == SYNC_BYTE) rx_nx = R_DATA;
      R_DATA: begin
        if (byte_take) begin
          if (byte_cnt == CW'(HEADER_BYTES - 1)) rx_nx = R_CSUM;
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          rx_nx       = R_SYNC;
        end
      end
      R_CSUM: begin
        if (byte_take) begin
          rx_nx = R_SYNC;
          if (rx_data == csum) csum_hit = 1'b1;
          else                 csum_miss = 1'b1;
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          rx_nx       = R_SYNC;
        end
      end
      default: rx_nx = R_SYNC;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_clear     <= 1'b0;
      header_valid <= 1'b0;
      header_data  <= '0;
      staging      <= '0;
      byte_cnt     <= '0;
      csum         <= 8'h00;
      timer        <= '0;
    end else begin
      rx_clear     <= byte_take;
      header_valid <= csum_hit;
      if (csum_hit) header_data <= staging;

      if (rx_state == R_SYNC) begin
        byte_cnt <= '0;
        csum     <= 8'h00;
      end else if (rx_state == R_DATA && byte_take) begin
        staging  <= {staging[HW-9:0], rx_data};
        byte_cnt <= byte_cnt + CW'(1);
        csum     <= csum + rx_data;
      end

      // Idle-gap timer: restarts on every accepted byte and only runs inside a frame.
      if (rx_state == R_SYNC || byte_take || timeout_hit) timer <= '0;
      else                                                  timer <= timer + TW'(1);
    end
  end

`ifdef LINK_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_bad_csum <= 16'h0;
      stat_timeouts <= 16'h0;
    end else begin
      if (csum_miss && stat_bad_csum != 16'hFFFF)   stat_bad_csum <= stat_bad_csum + 16'h1;
      if (timeout_hit && stat_timeouts != 16'hFFFF) stat_timeouts <= stat_timeouts + 16'h1;
    end
  end
`endif

  link_tx_sequencer #(
    .ACK_BYTE   (ACK_BYTE),
    .NAK_BYTE   (NAK_BYTE),
    .NONCE_MARK (NONCE_MARK)
  ) u_tx_seq (
    .clock       (clock),
    .reset       (reset),
    .ack_req     (csum_hit),
    .nak_req     (csum_miss),
    .tx_busy     (tx_busy),
    .nonce_in    (nonce_in),
    .nonce_valid (nonce_valid),
    .nonce_ready (nonce_ready),
    .tx_data     (tx_data),
    .tx_wr_en    (tx_wr_en),
    .tx_state    (tx_state_dbg)
  );

endmodule
